float_addsub_pipe: RTL and testbench

Parametrised, fully pipelined floating-point adder/subtractor; successor to the fixed 32-bit, magnitude-only subtract pipeline. It handles signs, add/sub op select, IEEE-style special values and optional round-to-nearest-even, and carries a valid bit down the pipe. It sits in the float datapath beside the multiplier and accepts one operation per cycle at a fixed latency.

---
 rtl/float_pkg.sv | 32 +++
 rtl/float_lzc.sv | 18 +
 rtl/float_addsub_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_float_addsub_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared widths, field helpers and constants for the floating-point add/sub pipeline.
package float_pkg;

  // Cycles from in_valid being sampled to out_valid.
  localparam int unsigned LAT = 5;

  // Flag vector layout {invalid, overflow, underflow, zero}.
  localparam int unsigned FLAG_W         = 4;
  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_ZERO      = 0;

  // Special-value outcome resolved at unpack and carried to the output stage.
  typedef enum logic [1:0] {
    SpNone,
    SpInf,
    SpNan
  } special_e;

  // Extract a field of 'width' bits at 'lsb' from a word of up to 64 bits.
  function automatic logic [63:0] get_field(logic [63:0] word, int unsigned lsb,
                                            int unsigned width);
    return (word >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  // Quiet NaN {0, all-ones exponent, mantissa msb set, rest zero}.
  function automatic logic [63:0] qnan_word(int unsigned exp_w, int unsigned man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/float_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module float_lzc #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    cnt_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/float_addsub_pipe.sv
// Pipelined floating-point adder/subtractor, one op per cycle, fixed latency LAT.
// Define FLOAT_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results truncate.
module float_addsub_pipe
  import float_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [FLAG_W-1:0]      flags
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W  = MAN_W + 1;        // hidden bit + mantissa
  localparam int unsigned EXT_W  = MAN_W + 4;        // significand + guard/round/sticky
  localparam int unsigned SUM_W  = MAN_W + 5;        // EXT_W plus carry
  localparam int unsigned WIDE_W = SIG_W + MAN_W + 3;
  localparam int unsigned LZ_W   = MAN_W + 2;
  localparam int unsigned CNT_W  = $clog2(LZ_W + 1);
  localparam int unsigned XE_W   = EXP_W + 2;        // signed working exponent
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = W'(qnan_word(EXP_W, MAN_W));

  typedef struct packed {
    logic bsgn; logic ssgn;
    logic [EXP_W-1:0] bexp; logic [EXP_W-1:0] sexp;
    logic [SIG_W-1:0] bsig; logic [SIG_W-1:0] ssig;
    special_e sp; logic isgn;
  } s1_t;
  typedef struct packed {
    logic bsgn; logic ssgn; logic [EXP_W-1:0] bexp;
    logic [EXT_W-1:0] bext; logic [EXT_W-1:0] sext;
    special_e sp; logic isgn;
  } s2_t;
  typedef struct packed {
    logic sgn; logic zero; logic [EXP_W-1:0] bexp; logic [SUM_W-1:0] sum;
    special_e sp; logic isgn;
  } s3_t;
  typedef struct packed {
    logic sgn; logic zero; logic [XE_W-1:0] exp; logic [EXT_W-1:0] mant;
    special_e sp; logic isgn;
  } s4_t;

  logic [LAT-1:0]    v_q;
  logic [W-1:0]      in_a_q, in_b_q;
  logic              in_op_q;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  s3_t               s3_d, s3_q;
  s4_t               s4_d, s4_q;
  logic              out_valid_q;
  logic [W-1:0]      res_d, res_q;
  logic [FLAG_W-1:0] flags_d, flags_q;

  // S1: unpack, flush exp==0 to zero, apply op to b's sign, order by magnitude.
  logic             a_sgn, b_sgn, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic [SIG_W-1:0] a_sig, b_sig;
  always_comb begin
    a_sgn  = in_a_q[W-1];
    b_sgn  = in_b_q[W-1] ^ in_op_q;
    a_exp  = EXP_W'(get_field(64'(in_a_q), MAN_W, EXP_W));
    b_exp  = EXP_W'(get_field(64'(in_b_q), MAN_W, EXP_W));
    a_man  = MAN_W'(get_field(64'(in_a_q), 0, MAN_W));
    b_man  = MAN_W'(get_field(64'(in_b_q), 0, MAN_W));
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_sig  = a_zero ? '0 : {1'b1, a_man};
    b_sig  = b_zero ? '0 : {1'b1, b_man};
    a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
    b_nan  = (b_exp == EXP_ONES) && (b_man != '0);
    a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
    b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
    swap   = {b_exp, b_sig} > {a_exp, a_sig};
    s1_d      = '0;
    s1_d.bsgn = swap ? b_sgn : a_sgn;
    s1_d.ssgn = swap ? a_sgn : b_sgn;
    s1_d.bexp = swap ? b_exp : a_exp;
    s1_d.sexp = swap ? a_exp : b_exp;
    s1_d.bsig = swap ? b_sig : a_sig;
    s1_d.ssig = swap ? a_sig : b_sig;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sgn != b_sgn))) s1_d.sp = SpNan;
    else if (a_inf || b_inf)                                    s1_d.sp = SpInf;
    else                                                        s1_d.sp = SpNone;
    s1_d.isgn = a_inf ? a_sgn : b_sgn;
  end

  // S2: align the smaller significand, folding shifted-out bits into sticky.
  logic [EXP_W-1:0]  d;
  logic [WIDE_W-1:0] wide;
  always_comb begin
    d    = s1_q.bexp - s1_q.sexp;
    wide = {s1_q.ssig, {(MAN_W + 3){1'b0}}} >> d;
    s2_d      = '0;
    s2_d.bsgn = s1_q.bsgn;
    s2_d.ssgn = s1_q.ssgn;
    s2_d.bexp = s1_q.bexp;
    s2_d.bext = {s1_q.bsig, 3'b000};
    // Past the sticky position the whole small operand becomes sticky.
    if (32'(d) >= 32'(MAN_W + 3)) s2_d.sext = {{(SIG_W + 2){1'b0}}, |s1_q.ssig};
    else                          s2_d.sext = {wide[WIDE_W-1:MAN_W+1], |wide[MAN_W:0]};
    s2_d.sp   = s1_q.sp;
    s2_d.isgn = s1_q.isgn;
  end

  // S3: add or subtract magnitudes; exact cancellation yields +0.
  logic eff_sub;
  always_comb begin
    eff_sub   = s2_q.bsgn ^ s2_q.ssgn;
    s3_d      = '0;
    s3_d.sum  = eff_sub ? ({1'b0, s2_q.bext} - {1'b0, s2_q.sext})
                        : ({1'b0, s2_q.bext} + {1'b0, s2_q.sext});
    s3_d.zero = (s3_d.sum == '0);
    s3_d.sgn  = (s3_d.zero && eff_sub) ? 1'b0 : s2_q.bsgn;
    s3_d.bexp = s2_q.bexp;
    s3_d.sp   = s2_q.sp;
    s3_d.isgn = s2_q.isgn;
  end

  // S4: normalise, either one right shift on carry or a left shift by the lzc.
  logic [CNT_W-1:0] lzc;
  float_lzc #(.WIDTH(LZ_W)) u_lzc (
    .in_i  (s3_q.sum[SUM_W-2:2]),
    .cnt_o (lzc)
  );
  always_comb begin
    s4_d      = '0;
    s4_d.sgn  = s3_q.sgn;
    s4_d.zero = s3_q.zero;
    if (s3_q.sum[SUM_W-1]) begin
      s4_d.mant = {s3_q.sum[SUM_W-1:2], |s3_q.sum[1:0]};
      s4_d.exp  = XE_W'(s3_q.bexp) + XE_W'(1);
    end else begin
      s4_d.mant = s3_q.sum[EXT_W-1:0] << lzc;
      s4_d.exp  = XE_W'(s3_q.bexp) - XE_W'(lzc);
    end
    s4_d.sp   = s3_q.sp;
    s4_d.isgn = s3_q.isgn;
  end

  // S5: round, range-check the exponent, apply special values; hold when idle.
  logic             rup;
  logic [SIG_W:0]   rnd;
  logic [XE_W-1:0]  exp_r;
  logic [MAN_W-1:0] man_f;
`ifdef FLOAT_ADDSUB_RNE_EN
  assign rup = s4_q.mant[2] & (s4_q.mant[1] | s4_q.mant[0] | s4_q.mant[3]);
`else
  logic unused_grs;
  assign rup        = 1'b0;
  assign unused_grs = ^s4_q.mant[2:0];
`endif
  always_comb begin
    rnd     = {1'b0, s4_q.mant[EXT_W-1:3]} + (SIG_W + 1)'(rup);
    exp_r   = s4_q.exp + XE_W'(rnd[SIG_W]);
    man_f   = rnd[SIG_W] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    res_d   = res_q;
    flags_d = flags_q;
    if (v_q[LAT-1]) begin
      flags_d = '0;
      if (s4_q.sp == SpNan) begin
        res_d                 = QNAN;
        flags_d[FLAG_INVALID] = 1'b1;
      end else if (s4_q.sp == SpInf) begin
        res_d = {s4_q.isgn, EXP_ONES, {MAN_W{1'b0}}};
      end else if (s4_q.zero) begin
        res_d              = {s4_q.sgn, {(W - 1){1'b0}}};
        flags_d[FLAG_ZERO] = 1'b1;
      end else if (!exp_r[XE_W-1] && (exp_r >= {2'b00, EXP_ONES})) begin
        res_d                  = {s4_q.sgn, EXP_ONES, {MAN_W{1'b0}}};
        flags_d[FLAG_OVERFLOW] = 1'b1;
      end else if (exp_r[XE_W-1] || (exp_r == '0)) begin
        res_d                   = {s4_q.sgn, {(W - 1){1'b0}}};
        flags_d[FLAG_UNDERFLOW] = 1'b1;
        flags_d[FLAG_ZERO]      = 1'b1;
      end else begin
        res_d = {s4_q.sgn, exp_r[EXP_W-1:0], man_f};
      end
    end
  end

  // Valid chain and output registers; the only reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      v_q         <= {v_q[LAT-2:0], in_valid};
      out_valid_q <= v_q[LAT-1];
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

  // Datapath registers advance every cycle regardless of valid.
  always_ff @(posedge clk) begin
    in_a_q  <= a;
    in_b_q  <= b;
    in_op_q <= op;
    s1_q    <= s1_d;
    s2_q    <= s2_d;
    s3_q    <= s3_d;
    s4_q    <= s4_d;
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Directed bench for float_addsub_pipe (single precision, default parameters).
module tb_float_addsub_pipe;
  import float_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        op;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] res;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;

  float_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .res       (res),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Exact single-precision encoding of a small integer.
  function automatic logic [31:0] int_to_f(input int v);
    int unsigned m;
    int          p;
    logic [31:0] r;
    if (v == 0) return 32'd0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(m << (23 - p));
    return r;
  endfunction

  // Issue one op alone and check it appears exactly LAT cycles later.
  task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic opv, input logic [31:0] er, input logic [3:0] ef);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    op       = opv;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      tick();
      check({tag, "_early"}, 32'(out_valid), 32'd0);
    end
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, res, er);
    check({tag, "_flags"}, 32'(flags), 32'(ef));
  endtask

  logic [31:0] rne_res;
  logic        ev [0:39];
  logic [31:0] er [0:39];
  logic [3:0]  ef [0:39];
  int          x, y, n;
  logic        o;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    op       = 1'b0;
    a        = '0;
    b        = '0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    tick();

    run_one("sub_3m1",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    run_one("sub_cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001);
    run_one("add_1p1",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    run_one("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0100);
    run_one("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
`ifdef FLOAT_ADDSUB_RNE_EN
    rne_res = 32'h3F800001;
`else
    rne_res = 32'h3F800000;
`endif
    run_one("rnd_above", 32'h3F800000, 32'h33C00000, 1'b0, rne_res, 4'b0000);
    run_one("rnd_tie",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000);
    run_one("nan_in",    32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_one("one_m_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    run_one("undf",      32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    run_one("negzero",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001);
    run_one("sub_swap",  32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 4'b0000);

    // 20 integer-valued ops (exact in any rounding mode) with in_valid 1101...
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (n < 20 && (c % 4) != 2) begin
        x        = int'($urandom_range(0, 2000)) - 1000;
        y        = int'($urandom_range(0, 2000)) - 1000;
        o        = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        a        = int_to_f(x);
        b        = int_to_f(y);
        op       = o;
        ev[c]    = 1'b1;
        er[c]    = int_to_f(o ? (x - y) : (x + y));
        ef[c]    = (er[c] == 32'd0) ? 4'b0001 : 4'b0000;
        n++;
      end else begin
        in_valid = 1'b0;
        ev[c]    = 1'b0;
        er[c]    = '0;
        ef[c]    = '0;
      end
      tick();
      if (c >= 5) begin
        check("seq_valid", 32'(out_valid), 32'(ev[c-5]));
        if (ev[c-5]) begin
          check("seq_res", res, er[c-5]);
          check("seq_flags", 32'(flags), 32'(ef[c-5]));
        end
      end
    end

    // Reset with three ops in flight: all of them must be discarded.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 32'h40400000;
      b        = 32'h3F800000;
      op       = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_res", res, 32'd0);
    check("mid_rst_flags", 32'(flags), 32'd0);
    tick();
    tick();
    check("hold_rst_res", res, 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    run_one("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    tick();
    check("post_rst_drop", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
